// File: rtl/mips32_scoreboard_if.sv
// Issue bus between the ID stage and the register-hazard scoreboard.
// The ID stage drives the instruction fields; the scoreboard answers with a stall.
interface mips32_scoreboard_if #(
  parameter int AW    = 5,
  parameter int LAT_W = 3
);
  logic             iss_valid;
  logic [AW-1:0]    iss_rs;
  logic             iss_rs_used;
  logic [AW-1:0]    iss_rt;
  logic             iss_rt_used;
  logic [AW-1:0]    iss_rd;
  logic             iss_wr;
  logic [LAT_W-1:0] iss_lat;
  logic             iss_stall;

  modport master (
    output iss_valid, iss_rs, iss_rs_used, iss_rt, iss_rt_used,
    output iss_rd, iss_wr, iss_lat,
    input  iss_stall
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rs_used, iss_rt, iss_rt_used,
    input  iss_rd, iss_wr, iss_lat,
    output iss_stall
  );
endinterface

// File: rtl/mips32_scoreboard.sv
// Register-hazard scoreboard for pipe_MIPS32: per-register latency countdowns,
// zero-latency issue stall, and a saturating count of stalled issue cycles.
module mips32_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int LAT_W    = 3,
  parameter bit BYPASS   = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                flush,
  mips32_scoreboard_if.slave  iss,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             pend_s;
  logic             rs_hz_s;
  logic             rt_hz_s;
  logic             waw_hz_s;
  logic             stall_s;
  logic             acc_s;

  // With forwarding, a result in its last countdown cycle is already usable.
  function automatic logic pend_f(input logic [LAT_W-1:0] c);
    if (BYPASS) begin
      return c > LAT_W'(1'b1);
    end else begin
      return c != {LAT_W{1'b0}};
    end
  endfunction

  // Hazard detection against current state only; register 0 never pends
  // because its counter is pinned at zero below.
  always_comb begin
    pend_s   = 1'b0;
    rs_hz_s  = 1'b0;
    rt_hz_s  = 1'b0;
    waw_hz_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_s   = pend_f(cnt_q[r]);
      rs_hz_s  = rs_hz_s  | (iss.iss_rs_used & pend_s & (iss.iss_rs == AW'(r)));
      rt_hz_s  = rt_hz_s  | (iss.iss_rt_used & pend_s & (iss.iss_rt == AW'(r)));
      waw_hz_s = waw_hz_s | (iss.iss_wr      & pend_s & (iss.iss_rd == AW'(r)));
    end
    stall_s = iss.iss_valid & (rs_hz_s | rt_hz_s | waw_hz_s);
    acc_s   = iss.iss_valid & ~stall_s & ~flush;
  end

  assign iss.iss_stall = stall_s;

  // Per-register next countdown: flush, then a fresh set, then decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (r == 0) begin
        cnt_d[r] = {LAT_W{1'b0}};
      end else if (flush) begin
        cnt_d[r] = {LAT_W{1'b0}};
      end else if (acc_s & iss.iss_wr & (iss.iss_rd == AW'(r)) &
                   (iss.iss_lat != {LAT_W{1'b0}})) begin
        cnt_d[r] = iss.iss_lat;
      end else if (cnt_q[r] != {LAT_W{1'b0}}) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1'b1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  // Saturating stall counter; a flushed cycle is not a lost issue slot.
  always_comb begin
    if (stall_s & ~flush & (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= {LAT_W{1'b0}};
      end
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy decode straight from the counters, no path from the issue inputs.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt_q[r] != {LAT_W{1'b0}});
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips32_scoreboard.sv
// Directed bench for mips32_scoreboard: three instances (bypass, no bypass,
// 4-bit stall counter) checked by a queue-based scoreboard at the falling edge.
module tb_mips32_scoreboard;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk1 = ~clk1;

  mips32_scoreboard_if #(.AW(5), .LAT_W(3)) if_b1 ();
  mips32_scoreboard_if #(.AW(5), .LAT_W(3)) if_b0 ();
  mips32_scoreboard_if #(.AW(5), .LAT_W(3)) if_c4 ();

  logic [31:0] bm_b1, bm_b0, bm_c4;
  logic [15:0] sc_b1, sc_b0;
  logic [3:0]  sc_c4;

  mips32_scoreboard #(.NUM_REGS(32), .LAT_W(3), .BYPASS(1'b1), .CNT_W(16)) u_b1 (
    .clk1(clk1), .rst_n(rst_n), .flush(flush), .iss(if_b1.slave),
    .busy_mask(bm_b1), .stall_cnt(sc_b1));
  mips32_scoreboard #(.NUM_REGS(32), .LAT_W(3), .BYPASS(1'b0), .CNT_W(16)) u_b0 (
    .clk1(clk1), .rst_n(rst_n), .flush(flush), .iss(if_b0.slave),
    .busy_mask(bm_b0), .stall_cnt(sc_b0));
  mips32_scoreboard #(.NUM_REGS(32), .LAT_W(3), .BYPASS(1'b1), .CNT_W(4)) u_c4 (
    .clk1(clk1), .rst_n(rst_n), .flush(flush), .iss(if_c4.slave),
    .busy_mask(bm_c4), .stall_cnt(sc_c4));

  typedef struct {
    int          sel;
    int          id;
    logic        es;
    logic [31:0] eb;
    logic [15:0] ec;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: every queued expectation belongs to the cycle now being sampled.
  always @(negedge clk1) begin
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sel)
        0: begin
          chk("stall", mon_e.id, {31'd0, if_b1.iss_stall}, {31'd0, mon_e.es});
          chk("busy_mask", mon_e.id, bm_b1, mon_e.eb);
          chk("stall_cnt", mon_e.id, {16'd0, sc_b1}, {16'd0, mon_e.ec});
        end
        1: begin
          chk("stall", mon_e.id, {31'd0, if_b0.iss_stall}, {31'd0, mon_e.es});
          chk("busy_mask", mon_e.id, bm_b0, mon_e.eb);
          chk("stall_cnt", mon_e.id, {16'd0, sc_b0}, {16'd0, mon_e.ec});
        end
        default: begin
          chk("stall", mon_e.id, {31'd0, if_c4.iss_stall}, {31'd0, mon_e.es});
          chk("busy_mask", mon_e.id, bm_c4, mon_e.eb);
          chk("stall_cnt", mon_e.id, {28'd0, sc_c4}, {16'd0, mon_e.ec});
        end
      endcase
    end
  end

  task automatic idle_all();
    if_b1.iss_valid = 1'b0; if_b1.iss_rs = 5'd0; if_b1.iss_rs_used = 1'b0; if_b1.iss_rt = 5'd0;
    if_b1.iss_rt_used = 1'b0; if_b1.iss_rd = 5'd0; if_b1.iss_wr = 1'b0; if_b1.iss_lat = 3'd0;
    if_b0.iss_valid = 1'b0; if_b0.iss_rs = 5'd0; if_b0.iss_rs_used = 1'b0; if_b0.iss_rt = 5'd0;
    if_b0.iss_rt_used = 1'b0; if_b0.iss_rd = 5'd0; if_b0.iss_wr = 1'b0; if_b0.iss_lat = 3'd0;
    if_c4.iss_valid = 1'b0; if_c4.iss_rs = 5'd0; if_c4.iss_rs_used = 1'b0; if_c4.iss_rt = 5'd0;
    if_c4.iss_rt_used = 1'b0; if_c4.iss_rd = 5'd0; if_c4.iss_wr = 1'b0; if_c4.iss_lat = 3'd0;
  endtask

  // One cycle of stimulus on the selected instance plus its expected response.
  task automatic step(input int sel, input int id, input logic rn, input logic fl, input logic v,
                      input logic [4:0] rs, input logic ru, input logic [4:0] rt, input logic tu,
                      input logic [4:0] rd, input logic wr, input logic [2:0] lat,
                      input logic es, input logic [31:0] eb, input logic [15:0] ec);
    exp_t e;
    @(posedge clk1);
    #1;
    rst_n = rn;
    flush = fl;
    idle_all();
    case (sel)
      0: begin
        if_b1.iss_valid = v; if_b1.iss_rs = rs; if_b1.iss_rs_used = ru; if_b1.iss_rt = rt;
        if_b1.iss_rt_used = tu; if_b1.iss_rd = rd; if_b1.iss_wr = wr; if_b1.iss_lat = lat;
      end
      1: begin
        if_b0.iss_valid = v; if_b0.iss_rs = rs; if_b0.iss_rs_used = ru; if_b0.iss_rt = rt;
        if_b0.iss_rt_used = tu; if_b0.iss_rd = rd; if_b0.iss_wr = wr; if_b0.iss_lat = lat;
      end
      default: begin
        if_c4.iss_valid = v; if_c4.iss_rs = rs; if_c4.iss_rs_used = ru; if_c4.iss_rt = rt;
        if_c4.iss_rt_used = tu; if_c4.iss_rd = rd; if_c4.iss_wr = wr; if_c4.iss_lat = lat;
      end
    endcase
    e.sel = sel; e.id = id; e.es = es; e.eb = eb; e.ec = ec;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int sel, input int id, input logic rn, input logic [31:0] eb,
                      input logic [15:0] ec);
    step(sel, id, rn, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, eb, ec);
  endtask

  initial begin
    int   stalls;
    logic es;
    idle_all();

    // Reset state of all three instances.
    idle(0, 1, 1'b0, 32'h0, 16'd0);
    idle(1, 2, 1'b0, 32'h0, 16'd0);
    idle(2, 3, 1'b0, 32'h0, 16'd0);

    // ADDI R1 (lat 3) then ADD R4,R1,R2 every cycle, with bypass.
    step(0, 100, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 3'd3, 1'b0, 32'h0, 16'd0);
    for (int c = 1; c <= 3; c++)
      step(0, 100 + c, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 3'd1,
           (c < 3), 32'h2, 16'(c - 1));
    idle(0, 104, 1'b1, 32'h10, 16'd2);
    idle(0, 105, 1'b1, 32'h0, 16'd2);

    // Same sequence without forwarding.
    step(1, 200, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 3'd3, 1'b0, 32'h0, 16'd0);
    for (int c = 1; c <= 4; c++)
      step(1, 200 + c, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 3'd1,
           (c < 4), (c < 4) ? 32'h2 : 32'h0, 16'(c - 1));
    idle(1, 205, 1'b1, 32'h10, 16'd3);
    idle(1, 206, 1'b1, 32'h0, 16'd3);

    // Writes to R0 are never tracked; reads of R0 never stall.
    step(0, 300, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd7, 1'b0, 32'h0, 16'd2);
    step(0, 301, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd7, 1'b0, 32'h0, 16'd2);
    step(0, 302, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0, 16'd2);

    // Flush with a dependent issue, then flush with a clean issue that must be dropped.
    step(0, 400, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd4, 1'b0, 32'h0, 16'd2);
    step(0, 401, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd3, 1'b1, 32'h20, 16'd2);
    idle(0, 402, 1'b1, 32'h0, 16'd2);
    step(0, 403, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd3, 1'b0, 32'h0, 16'd2);
    idle(0, 404, 1'b1, 32'h0, 16'd2);

    // 4-bit stall counter: R1 re-armed with lat 7 whenever it reaches its bypass cycle.
    step(2, 500, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 3'd7, 1'b0, 32'h0, 16'd0);
    stalls = 0;
    for (int k = 1; k <= 21; k++) begin
      es = (((k - 1) % 7) < 6);
      step(2, 500 + k, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 3'd7,
           es, 32'h2, (stalls > 15) ? 16'd15 : 16'(stalls));
      if (es) stalls++;
    end
    idle(2, 522, 1'b1, 32'h2, 16'd15);

    // R3 at cnt 1 re-set to 5 without a WAW stall; confirm 5 by stall length; async reset.
    step(0, 600, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd2, 1'b0, 32'h0, 16'd2);
    idle(0, 601, 1'b1, 32'h8, 16'd2);
    step(0, 602, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd5, 1'b0, 32'h8, 16'd2);
    for (int c = 3; c <= 7; c++)
      step(0, 600 + c, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0,
           (c < 7), 32'h8, 16'(c - 1));
    step(0, 608, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd6, 1'b0, 32'h0, 16'd6);
    idle(0, 609, 1'b1, 32'h8, 16'd6);
    idle(0, 610, 1'b0, 32'h0, 16'd0);
    idle(0, 611, 1'b1, 32'h0, 16'd0);
    idle(0, 612, 1'b1, 32'h0, 16'd0);

    @(negedge clk1);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips32_scoreboard.md
Name: mips32_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the pipe_MIPS32 family.
- Tracks in-flight destination registers and stalls dependent instructions at issue, so programs no longer need dummy OR R7,R7,R7 spacers between dependent instructions.
- Sits between the ID and EX stages and drives the pipeline stall.
- Generalises register count, latency range and bypass mode, and adds a saturating stall counter.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hard-wired and never tracked
AW, $clog2(NUM_REGS), register address width
LAT_W, 3, width of the per-register latency countdown; max latency 2**LAT_W-1
BYPASS, 1, 1 = result forwarded in its final countdown cycle (cnt==1 does not stall); 0 = no forwarding
CNT_W, 16, stall-counter width

Ports:
clk1  input  1  single pipeline clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all tracking (taken branch, halt)
iss_valid  input  1  ID stage presents an instruction
iss_rs  input  AW  source register 1
iss_rs_used  input  1  instruction reads iss_rs
iss_rt  input  AW  source register 2
iss_rt_used  input  1  instruction reads iss_rt
iss_rd  input  AW  destination register
iss_wr  input  1  instruction writes iss_rd
iss_lat  input  LAT_W  cycles from issue until the result is available
iss_stall  output  1  combinational; hold the ID stage this cycle
busy_mask  output  NUM_REGS  bit r = cnt[r] != 0; bit 0 is always 0
stall_cnt  output  CNT_W  number of cycles with iss_valid & iss_stall, saturating

Behaviour:
- State: cnt[r] (LAT_W bits) for r = 1..NUM_REGS-1, plus stall_cnt.
- Reset: rst_n low clears all cnt and stall_cnt to 0 immediately, without waiting for a clock edge. busy_mask=0 and iss_stall=0 (given iss_valid=0) during reset.
- pend(r):
  - r == 0: always 0.
  - BYPASS=1: cnt[r] > 1.
  - BYPASS=0: cnt[r] != 0.
- iss_stall = iss_valid & (rs_hz | rt_hz | waw_hz), where:
  - rs_hz = iss_rs_used & pend(iss_rs)
  - rt_hz = iss_rt_used & pend(iss_rt)
  - waw_hz = iss_wr & pend(iss_rd)
  - The output is purely combinational from current state and inputs; zero latency.
- Accept: acc = iss_valid & ~iss_stall & ~flush.
- Per-register update, each rising edge, in priority order:
  1. flush=1: cnt[r] <= 0 for all r. The same-cycle issue is dropped.
  2. acc & iss_wr & iss_rd == r & r != 0 & iss_lat != 0: cnt[r] <= iss_lat. A new set overrides the decrement, including the case cnt[r]==1 under BYPASS.
  3. Otherwise, cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  4. Otherwise, hold.
- Writes with iss_lat==0 or iss_rd==0 are accepted but not tracked.
- Counters never wrap: they count down to 0 and stop.
- stall_cnt increments when iss_valid & iss_stall & ~flush. It saturates at 2**CNT_W-1 and is not cleared by flush.
- Source equal to destination (e.g. ADD R4,R4,R1): hazards are checked against current state only. The instruction's own set applies after the edge.
- rs == rt: one hazard, same result.
- Any reset assertion mid-operation returns the block to the empty state.
- busy_mask is a registered-state decode and carries no combinational path from the issue inputs.

Test Plan:
1. Reset, BYPASS=1, issue ADDI R1 (rd=1, lat=3) at cycle 0, then ADD R4,R1,R2 every cycle -> busy_mask=0x2 after cycle 0; iss_stall=1 in cycles 1 and 2 (cnt 3,2); iss_stall=0 in cycle 3 (cnt=1, bypass); accepted in cycle 3; stall_cnt=2.
2. Same sequence with BYPASS=0 -> stall in cycles 1, 2 and 3; accept in cycle 4; stall_cnt=3.
3. Writes to R0 with lat=7, followed by a read of R0 -> busy_mask stays 0 and iss_stall never asserts.
4. R5 at cnt=4, pulse flush together with a valid R5-dependent issue -> the issue is dropped, busy_mask=0 next cycle, stall_cnt increments by 0.
5. CNT_W=4, hold a permanent hazard for 20 cycles -> stall_cnt sticks at 15.
6. R3 at cnt=1 (BYPASS=1), issue a new write to R3 with lat=5 -> accepted (no WAW stall) and cnt[R3]=5 next cycle. Then assert rst_n=0 mid-countdown, between clock edges -> busy_mask=0 immediately, and it stays 0 after release.
